// File: rtl/bullet_pool_if.sv
// bullet_pool_if: groups the keyboard/collision inputs and the per-slot
// sprite outputs of bullet_pool.
//   master: game-side driver (keycode, player_X_position, hit) that
//           observes the bullet state.
//   slave : bullet_pool itself.
// Signals:
//   keycode            current keyboard code
//   player_X_position  player X, latched into a slot at spawn
//   hit                per-slot hit from collision logic (bit i = slot i)
//   bullet_X/bullet_Y  slot i coordinate at [10i+9:10i]
//   bullet_active      slot i is on screen
//   fire_event         one-frame pulse when a shot is accepted
//   free_slots         number of inactive slots
// Handshake: there is no valid/ready pair here. fire_event is a one-cycle
// event pulse with no backpressure; consumers must sample it on the cycle it
// is high. All other outputs are level signals valid every cycle.
interface bullet_pool_if #(
  parameter int NUM_BULLETS = 4
);
  logic [7:0]                         keycode;
  logic [9:0]                         player_X_position;
  logic [NUM_BULLETS-1:0]             hit;
  logic [10*NUM_BULLETS-1:0]          bullet_X;
  logic [10*NUM_BULLETS-1:0]          bullet_Y;
  logic [NUM_BULLETS-1:0]             bullet_active;
  logic                               fire_event;
  logic [$clog2(NUM_BULLETS+1)-1:0]   free_slots;

  modport master (
    output keycode, player_X_position, hit,
    input  bullet_X, bullet_Y, bullet_active, fire_event, free_slots
  );

  modport slave (
    input  keycode, player_X_position, hit,
    output bullet_X, bullet_Y, bullet_active, fire_event, free_slots
  );
endinterface

// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player-projectile manager, one update per frame.
// Each slot latches its own X/Y/active. A rising press of FIRE_KEY spawns a
// bullet in the lowest free slot at (player X, Y_START) unless a refire
// cooldown is running or all slots are busy. Active bullets move up by
// Y_STEP per frame and retire on a hit or at the ceiling.
// Ports:
//   frame_clk     sole clock, one rising edge per video frame
//   Reset         synchronous active-high reset
//   bus           bullet_pool_if.slave (inputs and sprite outputs)
//   cool_state_o  cooldown FSM state (0 = READY, 1 = COOL), debug only
module bullet_pool #(
  parameter int          NUM_BULLETS = 4,
  parameter int          Y_START     = 136,
  parameter int          Y_MIN       = 0,
  parameter int          Y_STEP      = 1,
  parameter int          COOLDOWN    = 8,
  parameter logic [7:0]  FIRE_KEY    = 8'h44
) (
  input  logic          frame_clk,
  input  logic          Reset,
  bullet_pool_if.slave  bus,
  output logic          cool_state_o
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam int FW = $clog2(NUM_BULLETS + 1);
  localparam logic [9:0]  Y_INIT  = 10'(Y_START);
  // Ceiling test and step are done at 11 bits so Y never wraps.
  localparam logic [10:0] Y_LIMIT = 11'(Y_MIN + Y_STEP);
  localparam logic [10:0] Y_DEC   = 11'(Y_STEP);

  typedef enum logic {READY = 1'b0, COOL = 1'b1} cool_state_e;

  cool_state_e             state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    key_prev_q;
  logic                    fire_event_q, fire_event_d;
  logic [NUM_BULLETS-1:0]  active_q, active_d;
  logic [9:0]              x_q [NUM_BULLETS];
  logic [9:0]              x_d [NUM_BULLETS];
  logic [9:0]              y_q [NUM_BULLETS];
  logic [9:0]              y_d [NUM_BULLETS];

  logic                    key_now;
  logic                    fire_req;
  logic                    any_free;
  logic                    accept;
  logic                    found;
  logic [NUM_BULLETS-1:0]  spawn_oh;
  logic [10:0]             y_ext;
  logic [FW-1:0]           free_cnt;

  assign key_now  = (bus.keycode == FIRE_KEY);
  assign fire_req = key_now && !key_prev_q;
  assign any_free = ~&active_q;
  // A rejected request is simply dropped: key_prev still updates, so holding
  // the key never retries.
  assign accept   = fire_req && (state_q == READY) && any_free;

  // Lowest-index free slot, judged on the state at the start of the cycle.
  always_comb begin
    spawn_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i] && !found) begin
        spawn_oh[i] = accept;
        found       = 1'b1;
      end
    end
  end

  // Cooldown FSM: READY until a shot is accepted, then COOL for COOLDOWN
  // frames so the next shot may land COOLDOWN+1 frames after the previous.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      READY: begin
        if (accept && (COOLDOWN != 0)) begin
          cnt_d   = CW'(COOLDOWN);
          state_d = COOL;
        end
      end
      COOL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = READY;
      end
      default: begin
        state_d = READY;
        cnt_d   = '0;
      end
    endcase
  end

  // Per-slot update. A slot that spawns this cycle was inactive at the start,
  // so its hit bit and motion are ignored until the following cycle.
  always_comb begin
    active_d     = active_q;
    x_d          = x_q;
    y_d          = y_q;
    y_ext        = '0;
    fire_event_d = accept;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      y_ext = {1'b0, y_q[i]};
      if (active_q[i]) begin
        if (bus.hit[i]) begin
          active_d[i] = 1'b0;
          y_d[i]      = Y_INIT;
        end else if (y_ext <= Y_LIMIT) begin
          active_d[i] = 1'b0;
          y_d[i]      = Y_INIT;
        end else begin
          y_d[i] = 10'(y_ext - Y_DEC);
        end
      end else if (spawn_oh[i]) begin
        active_d[i] = 1'b1;
        x_d[i]      = bus.player_X_position;
        y_d[i]      = Y_INIT;
      end
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= READY;
      cnt_q        <= '0;
      key_prev_q   <= 1'b0;
      fire_event_q <= 1'b0;
      active_q     <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= Y_INIT;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_prev_q   <= key_now;
      fire_event_q <= fire_event_d;
      active_q     <= active_d;
      x_q          <= x_d;
      y_q          <= y_d;
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i]) free_cnt = free_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.bullet_X = '0;
    bus.bullet_Y = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bus.bullet_X[10*i +: 10] = x_q[i];
      bus.bullet_Y[10*i +: 10] = y_q[i];
    end
  end

  assign bus.bullet_active = active_q;
  assign bus.fire_event    = fire_event_q;
  assign bus.free_slots    = free_cnt;
  assign cool_state_o      = (state_q == COOL);

endmodule

// File: tb/tb_bullet_pool.sv
module tb_bullet_pool;

  logic frame_clk;
  logic Reset;
  logic cool_state;

  int n_compared;
  int n_mismatched;
  int fires;

  bullet_pool_if #(.NUM_BULLETS(4)) bus ();

  bullet_pool #(
    .NUM_BULLETS(4), .Y_START(136), .Y_MIN(0), .Y_STEP(1),
    .COOLDOWN(8), .FIRE_KEY(8'h44)
  ) dut (
    .frame_clk    (frame_clk),
    .Reset        (Reset),
    .bus          (bus),
    .cool_state_o (cool_state)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // driver tasks
  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [9:0] slot_x(input int i);
    return bus.bullet_X[10*i +: 10];
  endfunction

  function automatic logic [9:0] slot_y(input int i);
    return bus.bullet_Y[10*i +: 10];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    Reset = 1'b1;
    bus.keycode = 8'h00;
    bus.player_X_position = 10'd0;
    bus.hit = 4'b0000;
    idle(2);
    Reset = 1'b0;
    step();

    // reset state
    check("rst_active", bus.bullet_active, 4'b0000);
    check("rst_y0", slot_y(0), 136);
    check("rst_y3", slot_y(3), 136);
    check("rst_x0", slot_x(0), 0);
    check("rst_fire", bus.fire_event, 0);
    check("rst_free", bus.free_slots, 4);
    check("rst_cool", cool_state, 0);

    // single shot, then flight with X latched
    bus.keycode = 8'h44;
    bus.player_X_position = 10'd200;
    step();
    check("spawn_active", bus.bullet_active, 4'b0001);
    check("spawn_x0", slot_x(0), 200);
    check("spawn_y0", slot_y(0), 136);
    check("spawn_fire", bus.fire_event, 1);
    check("spawn_free", bus.free_slots, 3);
    check("spawn_cool", cool_state, 1);
    bus.keycode = 8'h00;
    step();
    check("fire_pulse_end", bus.fire_event, 0);
    check("move1_y0", slot_y(0), 135);
    bus.player_X_position = 10'd300;
    idle(9);
    check("move10_y0", slot_y(0), 126);
    check("latched_x0", slot_x(0), 200);

    // key held for 50 frames: one spawn only
    fires = 0;
    bus.keycode = 8'h44;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus.fire_event) fires++;
    end
    bus.keycode = 8'h00;
    check("hold_fires", fires, 1);
    check("hold_active", bus.bullet_active, 4'b0011);
    check("hold_y0", slot_y(0), 76);
    check("hold_y1", slot_y(1), 87);
    check("hold_x1", slot_x(1), 300);

    // clear everything with two bullets in flight
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("rst2_active", bus.bullet_active, 4'b0000);
    check("rst2_y1", slot_y(1), 136);
    step();

    // cooldown: 8 frames apart rejected, 9 apart accepted
    bus.keycode = 8'h44; step();
    check("cd_first_fire", bus.fire_event, 1);
    check("cd_first_active", bus.bullet_active, 4'b0001);
    bus.keycode = 8'h00; step();
    idle(6);
    bus.keycode = 8'h44; step();
    check("cd8_fire", bus.fire_event, 0);
    check("cd8_active", bus.bullet_active, 4'b0001);
    check("cd8_free", bus.free_slots, 3);
    bus.keycode = 8'h00; step();
    bus.keycode = 8'h44; step();
    check("cd10_fire", bus.fire_event, 1);
    check("cd10_active", bus.bullet_active, 4'b0011);
    check("cd10_free", bus.free_slots, 2);
    bus.keycode = 8'h00; step();
    idle(7);
    bus.keycode = 8'h44; step();
    check("cd9_fire", bus.fire_event, 1);
    check("cd9_active", bus.bullet_active, 4'b0111);
    check("cd9_free", bus.free_slots, 1);
    bus.keycode = 8'h00; step();
    idle(7);
    bus.keycode = 8'h44; step();
    check("fill_active", bus.bullet_active, 4'b1111);
    check("fill_free", bus.free_slots, 0);
    bus.keycode = 8'h00; step();
    idle(7);
    bus.keycode = 8'h44; step();
    check("full_fire", bus.fire_event, 0);
    check("full_active", bus.bullet_active, 4'b1111);
    check("full_free", bus.free_slots, 0);
    bus.keycode = 8'h00; step();

    // hit on slot 2, then the next press reuses slot 2
    bus.hit = 4'b0100; step();
    bus.hit = 4'b0000;
    check("hit2_active", bus.bullet_active, 4'b1011);
    check("hit2_y2", slot_y(2), 136);
    check("hit2_free", bus.free_slots, 1);
    bus.player_X_position = 10'd55;
    bus.keycode = 8'h44; step();
    check("reuse_fire", bus.fire_event, 1);
    check("reuse_active", bus.bullet_active, 4'b1111);
    check("reuse_x2", slot_x(2), 55);
    check("reuse_y2", slot_y(2), 136);
    bus.keycode = 8'h00; step();

    // reset mid-flight with 3 active; fire and hit in that cycle are ignored
    bus.hit = 4'b1000; step();
    check("hit3_active", bus.bullet_active, 4'b0111);
    Reset = 1'b1;
    bus.keycode = 8'h44;
    bus.hit = 4'b0001;
    step();
    Reset = 1'b0;
    bus.keycode = 8'h00;
    bus.hit = 4'b0000;
    check("rst3_active", bus.bullet_active, 4'b0000);
    check("rst3_free", bus.free_slots, 4);
    check("rst3_fire", bus.fire_event, 0);
    check("rst3_y0", slot_y(0), 136);
    check("rst3_x0", slot_x(0), 0);
    check("rst3_cool", cool_state, 0);
    step();

    // immediate press accepted; hit in the spawn cycle is ignored
    bus.player_X_position = 10'd321;
    bus.keycode = 8'h44;
    bus.hit = 4'b0001;
    step();
    check("post_rst_fire", bus.fire_event, 1);
    check("post_rst_active", bus.bullet_active, 4'b0001);
    check("post_rst_x0", slot_x(0), 321);
    bus.keycode = 8'h00;
    bus.hit = 4'b1110;
    step();
    bus.hit = 4'b0000;
    check("hit_inactive_active", bus.bullet_active, 4'b0001);
    check("hit_inactive_y0", slot_y(0), 135);
    check("hit_inactive_y1", slot_y(1), 136);

    // ceiling retirement with Y_STEP=1
    idle(134);
    check("ceil_pre_active", bus.bullet_active, 4'b0001);
    check("ceil_pre_y0", slot_y(0), 1);
    step();
    check("ceil_active", bus.bullet_active, 4'b0000);
    check("ceil_y0", slot_y(0), 136);
    check("ceil_free", bus.free_slots, 4);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
